// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared constants and FSM state type for the nibble-serial adder.
package rca_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/rca_serial_add_ctrl_rca4.sv
// rtl/rca_serial_add_ctrl_rca4.sv - 4-bit ripple-carry adder slice (RCA_4bit).
module RCA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

// File: rtl/rca_serial_add_ctrl.sv
// rtl/rca_serial_add_ctrl.sv - WIDTH-bit adder built from one RCA_4bit slice, one nibble per clock.
module rca_serial_add_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NIBBLE_W-1:0] rca_sum;
  logic                rca_cout;

  RCA_4bit u_rca (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        // New nibble enters at the top so after NIBBLES steps nibble 0 sits at the bottom.
        sum_sh_d = (sum_sh_q >> NIBBLE_W) | (WIDTH'(rca_sum) << (WIDTH - NIBBLE_W));
        carry_d  = rca_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_sh_d;
          cout_d  = rca_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_rca_serial_add_ctrl.sv
// tb/tb_rca_serial_add_ctrl.sv - directed self-checking bench for rca_serial_add_ctrl (WIDTH 16 and 4).
module tb_rca_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, busy;
  logic [15:0] sum;

  logic       n4_in_valid, n4_out_ready, n4_cin;
  logic [3:0] n4_a, n4_b;
  logic       n4_in_ready, n4_out_valid, n4_cout, n4_busy;
  logic [3:0] n4_sum;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int cyc;
  int acc[$];

  always #5 clk = ~clk;

  rca_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  rca_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(n4_in_valid), .in_ready(n4_in_ready),
    .a(n4_a), .b(n4_b), .cin(n4_cin), .out_valid(n4_out_valid), .out_ready(n4_out_ready),
    .sum(n4_sum), .cout(n4_cout), .busy(n4_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic cv, output int n);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a = '0; b = '0;
    n4_in_valid = 1'b0; n4_out_ready = 1'b0; n4_cin = 1'b0; n4_a = '0; n4_b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    do_op(16'h00FF, 16'h0001, 1'b0, lat);
    chk("op1_latency", lat, 4);
    chk("op1_sum", sum, 16'h0100);
    chk("op1_cout", cout, 0);
    chk("op1_busy", busy, 1);
    chk("op1_in_ready", in_ready, 0);
    consume();
    chk("op1_idle_out_valid", out_valid, 0);
    chk("op1_idle_sum_hold", sum, 16'h0100);

    do_op(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("op2_latency", lat, 4);
    chk("op2_sum", sum, 16'h0000);
    chk("op2_cout", cout, 1);
    consume();

    do_op(16'h1234, 16'h4321, 1'b1, lat);
    chk("op3_sum", sum, 16'h5556);
    chk("op3_cout", cout, 0);
    consume();

    a = 16'h1234; b = 16'h4321; cin = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; cyc = 0;
    for (int i = 0; i < 14; i++) begin
      if (in_ready) acc.push_back(cyc);
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_accept_count", acc.size(), 3);
    if (acc.size() >= 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 6);
      chk("b2b_gap2", acc[2] - acc[1], 6);
    end
    wait_valid(lat);
    chk("b2b_sum", sum, 16'h5556);
    consume();

    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_run_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);

    do_op(16'h0003, 16'h0004, 1'b0, lat);
    chk("op5_latency", lat, 4);
    chk("op5_sum", sum, 16'h0007);
    chk("op5_cout", cout, 0);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("done_rst_out_valid", out_valid, 0);
    chk("done_rst_sum", sum, 0);
    chk("done_rst_in_ready", in_ready, 1);

    do_op(16'hF0F0, 16'h0F0F, 1'b1, lat);
    chk("bp_latency", lat, 4);
    a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h0000);
      chk("bp_cout", cout, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    consume();
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    n4_a = 4'hF; n4_b = 4'h1; n4_cin = 1'b1; n4_in_valid = 1'b1;
    tick();
    n4_in_valid = 1'b0;
    chk("w4_run_out_valid", n4_out_valid, 0);
    tick();
    chk("w4_out_valid", n4_out_valid, 1);
    chk("w4_sum", n4_sum, 4'h1);
    chk("w4_cout", n4_cout, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
